// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and RISC-V opcode constants used by fetch, PC stall logic and decode.
package ifetch_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0013;

  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } fetch_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch: single-outstanding imem request, holds the returned word for decode.
module ifetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(ifetch_pkg::NOP_INSTR)
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [XLEN-1:0] IP,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] INSTR,
  output logic [XLEN-1:0] INSTR_PC,
  output logic [XLEN-1:0] INSTR_PC_NEXT,
  output logic [6:0]      OP,
  output logic            INSTR_VALID,
  input  logic            INSTR_READY,
  output logic            FETCH_BUSY
);

  import ifetch_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] ip_aligned, redirect_aligned;

  assign ip_aligned       = IP & ALIGN_MASK;
  assign redirect_aligned = REDIRECT_PC & ALIGN_MASK;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      drop_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Next state, datapath updates and state-decoded handshake outputs; REDIRECT wins every tie
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drop_d      = drop_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    imem_req    = 1'b0;
    imem_addr   = '0;
    FETCH_BUSY  = 1'b0;
    INSTR_VALID = 1'b0;

    unique case (state_q)
      IDLE: begin
        addr_d  = REDIRECT ? redirect_aligned : ip_aligned;
        state_d = REQ;
      end
      REQ: begin
        imem_req   = 1'b1;
        imem_addr  = addr_q;
        FETCH_BUSY = 1'b1;
        if (REDIRECT) addr_d = redirect_aligned;
        if (imem_gnt) begin
          state_d = WAIT;
          drop_d  = REDIRECT;
        end
      end
      WAIT: begin
        FETCH_BUSY = 1'b1;
        if (REDIRECT) addr_d = redirect_aligned;
        if (imem_rvalid) begin
          if (drop_q || REDIRECT) begin
            // stale response: discard it and refetch from the redirect target
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = addr_q;
            state_d    = HOLD;
          end
        end else if (REDIRECT) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        INSTR_VALID = ~REDIRECT;
        if (REDIRECT) begin
          addr_d  = redirect_aligned;
          state_d = REQ;
        end else if (INSTR_READY) begin
          addr_d  = ip_aligned;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode-facing view of the held word; OP falls back to OP-IMM so stall logic never sees a stale branch
  assign INSTR         = instr_q;
  assign INSTR_PC      = instr_pc_q;
  assign INSTR_PC_NEXT = instr_pc_q + INSTR_STEP;
  assign OP            = INSTR_VALID ? instr_q[6:0] : OPC_OPIMM;

endmodule
